// File: rtl/tone_sequencer.sv
// tone_sequencer: accepts (pitch, octave, duration) notes over valid/ready
// and drives a square-wave speaker for each note's duration.
// Optional silent inter-note gap is compiled in with `TONE_SEQ_GAP_EN`.
// Without it, a note ends directly in IDLE (legato).
module tone_sequencer #(
    parameter int CLK_DIV_W = 9,
    parameter int OCT_W     = 3,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 25000,
    parameter int GAP_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 note_valid,
    output logic                 note_ready,
    input  logic [3:0]           note_pitch,
    input  logic [OCT_W-1:0]     note_octave,
    input  logic [DUR_W-1:0]     note_dur,
    output logic                 speaker,
    output logic                 busy,
    output logic [CLK_DIV_W-1:0] tone_div
);

    localparam int OCT_BITS = 1 << OCT_W;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    // Remaining counter holds either a note duration or the gap length.
    localparam int REM_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t                state;
    logic [CLK_DIV_W-1:0]  counter_note;
    logic [OCT_BITS-1:0]   counter_octave;
    logic [OCT_BITS-1:0]   oct_reload;
    logic                  rest;
    logic [PS_W-1:0]       prescaler;
    logic [REM_W-1:0]      remaining;

    logic [CLK_DIV_W-1:0]  new_div;
    logic [OCT_BITS-1:0]   new_oreload;
    logic                  new_rest;
    logic                  tick;

    function automatic logic [CLK_DIV_W-1:0] pitch_div(input logic [3:0] p);
        logic [8:0] d;
        case (p)
            4'd1:    d = 9'd511;
            4'd2:    d = 9'd482;
            4'd3:    d = 9'd455;
            4'd4:    d = 9'd430;
            4'd5:    d = 9'd405;
            4'd6:    d = 9'd383;
            4'd7:    d = 9'd361;
            4'd8:    d = 9'd341;
            4'd9:    d = 9'd322;
            4'd10:   d = 9'd303;
            4'd11:   d = 9'd286;
            4'd12:   d = 9'd270;
            default: d = 9'd0;
        endcase
        return CLK_DIV_W'(d);
    endfunction

    // Decode the offered note: divider, octave reload and rest flag.
    // Shift amount (2^OCT_W-1-octave) is simply the bitwise inverse of octave.
    always_comb begin
        new_div     = pitch_div(note_pitch);
        new_rest    = (note_pitch == 4'd0) || (note_pitch > 4'd12);
        new_oreload = (OCT_BITS'(1) << (~note_octave)) - OCT_BITS'(1);
    end

    assign tick       = (prescaler == PS_LAST);
    assign note_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // Sequencer FSM with tone counters, tick prescaler and duration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            speaker        <= 1'b0;
            tone_div       <= '0;
            counter_note   <= '0;
            counter_octave <= '0;
            oct_reload     <= '0;
            rest           <= 1'b0;
            prescaler      <= '0;
            remaining      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    speaker  <= 1'b0;
                    tone_div <= '0;
                    if (note_valid && note_dur != '0) begin
                        state          <= PLAY;
                        rest           <= new_rest;
                        tone_div       <= new_rest ? '0 : new_div;
                        counter_note   <= new_div;
                        oct_reload     <= new_oreload;
                        counter_octave <= new_oreload;
                        prescaler      <= '0;
                        remaining      <= REM_W'(note_dur);
                    end
                end
                PLAY: begin
                    prescaler <= tick ? '0 : prescaler + PS_W'(1);
                    if (tick)
                        remaining <= remaining - REM_W'(1);
                    if (!rest) begin
                        if (counter_note == '0) begin
                            counter_note <= tone_div;
                            if (counter_octave == '0) begin
                                counter_octave <= oct_reload;
                                speaker        <= ~speaker;
                            end else begin
                                counter_octave <= counter_octave - OCT_BITS'(1);
                            end
                        end else begin
                            counter_note <= counter_note - CLK_DIV_W'(1);
                        end
                    end
                    // Last tick of the note: silence on the same edge.
                    if (tick && remaining == REM_W'(1)) begin
                        speaker   <= 1'b0;
                        tone_div  <= '0;
                        prescaler <= '0;
`ifdef TONE_SEQ_GAP_EN
                        if (GAP_TICKS == 0) begin
                            state <= IDLE;
                        end else begin
                            state     <= GAP;
                            remaining <= REM_W'(GAP_TICKS);
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                GAP: begin
                    speaker   <= 1'b0;
                    tone_div  <= '0;
                    prescaler <= tick ? '0 : prescaler + PS_W'(1);
                    if (tick) begin
                        remaining <= remaining - REM_W'(1);
                        if (remaining == REM_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
